// File: rtl/modbus_rtu_pkg.sv
// Shared types and constants for the Modbus-RTU receive path.
// No logic here; imported by the framer and its CRC engine.
package modbus_rtu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV    = 3'd1,
        ST_GAP     = 3'd2,
        ST_DISCARD = 3'd3,
        ST_CHECK   = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_SHORT = 3'd1;
    localparam logic [2:0] ERR_CRC   = 3'd2;
    localparam logic [2:0] ERR_OVF   = 3'd3;
    localparam logic [2:0] ERR_GAP   = 3'd4;

    localparam logic [15:0] CRC_POLY = 16'hA001;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam logic [7:0] FC_READ_HOLD    = 8'h03;
    localparam logic [7:0] FC_WRITE_SINGLE = 8'h06;
    localparam logic [7:0] FC_WRITE_MULTI  = 8'h10;

    typedef struct packed {
        logic [7:0]  func;
        logic [15:0] reg_addr;
        logic [15:0] reg_val;
    } hdr_t;

    // One reflected-polynomial shift of the CRC register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc);
        return crc[0] ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
    endfunction

endpackage

// File: rtl/crc16_modbus_serial.sv
// Bit-serial CRC-16/Modbus: accumulates one byte per start strobe into a running register.
// Latency: busy for 8 cycles after start; no backpressure, caller must not start while busy.
module crc16_modbus_serial
    import modbus_rtu_pkg::*;
(
    input  logic        i_clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    output logic        o_busy,
    output logic [15:0] o_crc
);

    logic [2:0] bit_cnt;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_crc   <= CRC_INIT;
            o_busy  <= 1'b0;
            bit_cnt <= 3'd0;
        end else if (i_clr) begin
            o_crc   <= CRC_INIT;
            o_busy  <= 1'b0;
            bit_cnt <= 3'd0;
        end else if (i_start) begin
            o_crc   <= o_crc ^ {8'h00, i_byte};
            o_busy  <= 1'b1;
            bit_cnt <= 3'd0;
        end else if (o_busy) begin
            o_crc   <= crc16_step(o_crc);
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                o_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/modbus_rtu_rx_framer.sv
// Modbus-RTU receive framer: silence-delimited frames, CRC check, address filter, header decode.
// Latency: result pulse ~T35+8 cycles after last byte; no backpressure, bytes arrive as strobes.
module modbus_rtu_rx_framer
    import modbus_rtu_pkg::*;
#(
    parameter int         CLK_HZ     = 29491200,
    parameter int         BAUD       = 9600,
    parameter logic [7:0] SLAVE_ADDR = 8'h01,
    parameter int         MAX_LEN    = 64
) (
    input  logic        i_clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic [5:0]  i_rd_addr,
    output logic [7:0]  o_rd_data,
    output logic        o_frame_valid,
    output logic        o_frame_err,
    output logic [2:0]  o_err_code,
    output logic        o_broadcast,
    output logic [7:0]  o_func,
    output logic [15:0] o_reg_addr,
    output logic [15:0] o_reg_val,
    output logic [6:0]  o_byte_cnt,
    output logic        o_busy
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int T15_CYC = BIT_CYC * 33 / 2;
    localparam int T35_CYC = BIT_CYC * 77 / 2;
    localparam int CW      = $clog2(T35_CYC + 1);
    localparam int AW      = $clog2(MAX_LEN);

    localparam logic [CW-1:0] T15_VAL = CW'(T15_CYC);
    localparam logic [CW-1:0] T35_VAL = CW'(T35_CYC);
    localparam logic [6:0]    MAX_CNT = 7'(MAX_LEN);

    state_t        state, next_state;
    logic [CW-1:0] idle_cnt;
    logic [6:0]    cnt;
    logic          ovf;
    logic [2:0]    err_lat;
    logic [7:0]    mem [MAX_LEN];
    logic [AW-1:0] wr_idx;
    hdr_t          hdr_q;

    logic          store_en, crc_clr, eval_en, disc_done;
    logic          crc_busy;
    logic [15:0]   crc_val;
    logic          addr_ok;

    crc16_modbus_serial u_crc (
        .i_clk   (i_clk),
        .rst_n   (rst_n),
        .i_clr   (crc_clr),
        .i_start (store_en),
        .i_byte  (i_rx_data),
        .o_busy  (crc_busy),
        .o_crc   (crc_val)
    );

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A byte arriving on the same cycle a silence threshold is hit always wins.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:    if (i_rx_valid) next_state = ST_RECV;
            ST_RECV:    if (!i_rx_valid && idle_cnt == T15_VAL) next_state = ST_GAP;
            ST_GAP: begin
                if (i_rx_valid)                next_state = ST_DISCARD;
                else if (idle_cnt == T35_VAL)  next_state = ST_CHECK;
            end
            ST_DISCARD: if (!i_rx_valid && idle_cnt == T35_VAL) next_state = ST_IDLE;
            ST_CHECK:   if (!crc_busy) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        store_en  = 1'b0;
        eval_en   = 1'b0;
        disc_done = 1'b0;
        case (state)
            ST_IDLE:    store_en  = i_rx_valid;
            ST_RECV:    store_en  = i_rx_valid && (cnt < MAX_CNT);
            ST_DISCARD: disc_done = (next_state == ST_IDLE);
            ST_CHECK:   eval_en   = !crc_busy;
            default:    ;
        endcase
        crc_clr = disc_done || eval_en;
    end

    assign wr_idx  = (state == ST_IDLE) ? '0 : cnt[AW-1:0];
    assign addr_ok = (mem[0] == SLAVE_ADDR) || (mem[0] == 8'h00);

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (i_rx_valid) begin
            idle_cnt <= '0;
        end else if (idle_cnt != T35_VAL) begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 7'd0;
            ovf     <= 1'b0;
            err_lat <= ERR_NONE;
        end else if (i_rx_valid) begin
            if (state == ST_IDLE) begin
                cnt     <= 7'd1;
                ovf     <= 1'b0;
                err_lat <= ERR_NONE;
            end else if (state == ST_RECV) begin
                if (cnt < MAX_CNT) cnt <= cnt + 7'd1;
                else               ovf <= 1'b1;
            end else if (state == ST_GAP) begin
                err_lat <= ERR_GAP;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (store_en) begin
            mem[wr_idx] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_data <= 8'h00;
        end else begin
            o_rd_data <= mem[i_rd_addr];
        end
    end

    // Fields only move on an accepted frame; rejected and foreign frames leave them intact.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
            o_err_code    <= ERR_NONE;
            o_broadcast   <= 1'b0;
            o_byte_cnt    <= 7'd0;
            o_busy        <= 1'b0;
            hdr_q         <= '0;
        end else begin
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
            if (state == ST_IDLE && i_rx_valid) begin
                o_busy <= 1'b1;
            end
            if (disc_done) begin
                o_busy      <= 1'b0;
                o_frame_err <= 1'b1;
                o_err_code  <= err_lat;
            end
            if (eval_en) begin
                o_busy <= 1'b0;
                if (ovf) begin
                    o_frame_err <= 1'b1;
                    o_err_code  <= ERR_OVF;
                end else if (cnt < 7'd4) begin
                    o_frame_err <= 1'b1;
                    o_err_code  <= ERR_SHORT;
                end else if (crc_val != 16'h0000) begin
                    o_frame_err <= 1'b1;
                    o_err_code  <= ERR_CRC;
                end else if (addr_ok) begin
                    o_frame_valid <= 1'b1;
                    o_err_code    <= ERR_NONE;
                    hdr_q         <= {mem[1], mem[2], mem[3], mem[4], mem[5]};
                    o_byte_cnt    <= cnt;
                    o_broadcast   <= (mem[0] == 8'h00);
                end
            end
        end
    end

    assign o_func     = hdr_q.func;
    assign o_reg_addr = hdr_q.reg_addr;
    assign o_reg_val  = hdr_q.reg_val;

endmodule

// File: tb/tb_modbus_rtu_rx_framer.sv
// Bench for modbus_rtu_rx_framer with a scaled-down bit clock so frames stay short.
// Expected outcomes are queued when a frame is built and popped when a result appears.
module tb_modbus_rtu_rx_framer;

    localparam int CLK_HZ   = 153600;
    localparam int BAUD     = 9600;
    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int T15      = BIT_CYC * 33 / 2;
    localparam int T35      = BIT_CYC * 77 / 2;
    localparam int SPACING  = 11 * BIT_CYC;
    localparam int WAIT_MAX = T35 + 64;
    localparam int GAP_XTRA = (T15 + T35) / 2 - SPACING;

    logic        i_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic [5:0]  i_rd_addr = 6'd0;
    logic [7:0]  o_rd_data;
    logic        o_frame_valid, o_frame_err, o_broadcast, o_busy;
    logic [2:0]  o_err_code;
    logic [7:0]  o_func;
    logic [15:0] o_reg_addr, o_reg_val;
    logic [6:0]  o_byte_cnt;

    modbus_rtu_rx_framer #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .SLAVE_ADDR(8'h01), .MAX_LEN(64)
    ) dut (
        .i_clk(i_clk), .rst_n(rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_frame_valid(o_frame_valid),
        .o_frame_err(o_frame_err), .o_err_code(o_err_code), .o_broadcast(o_broadcast),
        .o_func(o_func), .o_reg_addr(o_reg_addr), .o_reg_val(o_reg_val),
        .o_byte_cnt(o_byte_cnt), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (rst_n) begin
            assert (!(i_rx_valid && dut.u_crc.o_busy))
                else $error("FAIL rx_strobe_during_crc_busy");
        end
    end

    typedef struct {
        logic        v;
        logic        er;
        logic [2:0]  code;
        logic [7:0]  func;
        logic [15:0] ra;
        logic [15:0] rv;
        logic [6:0]  cnt;
        logic        bc;
    } exp_t;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] frame_q[$];
    exp_t       sb_q[$];
    exp_t       e;
    exp_t       last_good = '{1'b0, 1'b0, 3'd0, 8'h00, 16'h0000, 16'h0000, 7'd0, 1'b0};

    function automatic exp_t mk_ok(logic [7:0] func, logic [15:0] ra, logic [15:0] rv,
                                   logic [6:0] cnt, logic bc);
        exp_t x;
        x.v = 1'b1; x.er = 1'b0; x.code = 3'd0;
        x.func = func; x.ra = ra; x.rv = rv; x.cnt = cnt; x.bc = bc;
        return x;
    endfunction

    function automatic exp_t mk_err(logic [2:0] code);
        exp_t x;
        x = last_good;
        x.v = 1'b0; x.er = 1'b1; x.code = code;
        return x;
    endfunction

    function automatic void append_crc();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (frame_q[i]) begin
            c = c ^ {8'h00, frame_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        frame_q.push_back(c[7:0]);
        frame_q.push_back(c[15:8]);
    endfunction

    task automatic strobe(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) begin
            strobe(frame_q[i]);
            repeat (SPACING - 1) @(negedge i_clk);
        end
    endtask

    task automatic wait_pulse(output logic v, output logic er);
        v = 1'b0; er = 1'b0;
        for (int k = 0; k < WAIT_MAX; k++) begin
            @(negedge i_clk);
            if (o_frame_valid || o_frame_err) begin
                v = o_frame_valid; er = o_frame_err;
                break;
            end
        end
    endtask

    task automatic count_pulses(output int n);
        n = 0;
        for (int k = 0; k < WAIT_MAX; k++) begin
            @(negedge i_clk);
            if (o_frame_valid || o_frame_err) n++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        n_chk++; if ({o_frame_valid, o_frame_err, o_busy, o_broadcast} !== 4'b0000)
            $display("FAIL reset_flags: valid/err/busy/bc=%b want 0000",
                     {o_frame_valid, o_frame_err, o_busy, o_broadcast}); else n_pass++;
        n_chk++; if ({o_err_code, o_func, o_reg_addr, o_reg_val, o_byte_cnt} !== 50'd0)
            $display("FAIL reset_fields: code=%0d func=%h ra=%h rv=%h cnt=%0d want all 0",
                     o_err_code, o_func, o_reg_addr, o_reg_val, o_byte_cnt); else n_pass++;
        n_chk++; if (o_rd_data !== 8'h00)
            $display("FAIL reset_rd_data: got %h want 00", o_rd_data); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_good_frame(input string tag);
        logic v, er;
        send_frame();
        n_chk++; if (o_busy !== 1'b1)
            $display("FAIL %s_busy_during: got %b want 1", tag, o_busy); else n_pass++;
        wait_pulse(v, er);
        e = sb_q.pop_front();
        n_chk++; if (v !== e.v || er !== e.er)
            $display("FAIL %s_pulse: valid=%b err=%b want valid=%b err=%b", tag, v, er, e.v, e.er);
        else n_pass++;
        n_chk++; if (o_func !== e.func || o_reg_addr !== e.ra || o_reg_val !== e.rv)
            $display("FAIL %s_hdr: func=%h ra=%h rv=%h want func=%h ra=%h rv=%h",
                     tag, o_func, o_reg_addr, o_reg_val, e.func, e.ra, e.rv); else n_pass++;
        n_chk++; if (o_byte_cnt !== e.cnt || o_broadcast !== e.bc)
            $display("FAIL %s_cnt_bc: cnt=%0d bc=%b want cnt=%0d bc=%b",
                     tag, o_byte_cnt, o_broadcast, e.cnt, e.bc); else n_pass++;
        n_chk++; if (o_busy !== 1'b0)
            $display("FAIL %s_busy_after: got %b want 0", tag, o_busy); else n_pass++;
        last_good = e;
        i_rd_addr = 6'(frame_q.size() - 1);
        @(negedge i_clk);
        n_chk++; if (o_rd_data !== frame_q[frame_q.size() - 1])
            $display("FAIL %s_rd_last: got %h want %h", tag, o_rd_data, frame_q[frame_q.size() - 1]);
        else n_pass++;
        i_rd_addr = 6'd1;
        @(negedge i_clk);
        n_chk++; if (o_rd_data !== frame_q[1])
            $display("FAIL %s_rd_func: got %h want %h", tag, o_rd_data, frame_q[1]); else n_pass++;
    endtask

    task automatic test_basic();
        frame_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        sb_q.push_back(mk_ok(8'h03, 16'h0000, 16'h000A, 7'd8, 1'b0));
        test_good_frame("good");
    endtask

    task automatic test_crc_err();
        logic v, er;
        frame_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCC};
        sb_q.push_back(mk_err(3'd2));
        send_frame();
        wait_pulse(v, er);
        e = sb_q.pop_front();
        n_chk++; if (v !== e.v || er !== e.er)
            $display("FAIL crc_pulse: valid=%b err=%b want valid=%b err=%b", v, er, e.v, e.er); else n_pass++;
        n_chk++; if (o_err_code !== e.code)
            $display("FAIL crc_code: got %0d want %0d", o_err_code, e.code); else n_pass++;
        n_chk++; if (o_func !== e.func || o_byte_cnt !== e.cnt)
            $display("FAIL crc_fields_held: func=%h cnt=%0d want func=%h cnt=%0d",
                     o_func, o_byte_cnt, e.func, e.cnt); else n_pass++;
    endtask

    task automatic test_addr_filter();
        int n;
        frame_q = '{8'h05, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A};
        append_crc();
        send_frame();
        count_pulses(n);
        n_chk++; if (n !== 0) $display("FAIL filt_pulses: got %0d want 0", n); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL filt_busy: got %b want 0", o_busy); else n_pass++;
        n_chk++; if (o_func !== last_good.func || o_reg_val !== last_good.rv || o_byte_cnt !== last_good.cnt)
            $display("FAIL filt_fields_held: func=%h rv=%h cnt=%0d want func=%h rv=%h cnt=%0d",
                     o_func, o_reg_val, o_byte_cnt, last_good.func, last_good.rv, last_good.cnt);
        else n_pass++;
    endtask

    task automatic test_gap();
        logic v, er;
        frame_q = '{8'h01, 8'h03, 8'h00};
        sb_q.push_back(mk_err(3'd4));
        send_frame();
        repeat (GAP_XTRA) @(negedge i_clk);
        strobe(8'h00);
        wait_pulse(v, er);
        e = sb_q.pop_front();
        n_chk++; if (v !== e.v || er !== e.er)
            $display("FAIL gap_pulse: valid=%b err=%b want valid=%b err=%b", v, er, e.v, e.er); else n_pass++;
        n_chk++; if (o_err_code !== e.code)
            $display("FAIL gap_code: got %0d want %0d", o_err_code, e.code); else n_pass++;
        frame_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        sb_q.push_back(mk_ok(8'h03, 16'h0000, 16'h000A, 7'd8, 1'b0));
        test_good_frame("gap_recover");
    endtask

    task automatic test_overflow_short();
        logic v, er;
        frame_q.delete();
        for (int k = 0; k < 70; k++) frame_q.push_back(8'(k * 7 + 1));
        sb_q.push_back(mk_err(3'd3));
        send_frame();
        wait_pulse(v, er);
        e = sb_q.pop_front();
        n_chk++; if (v !== e.v || er !== e.er)
            $display("FAIL ovf_pulse: valid=%b err=%b want valid=%b err=%b", v, er, e.v, e.er); else n_pass++;
        n_chk++; if (o_err_code !== e.code || o_byte_cnt !== e.cnt)
            $display("FAIL ovf_code_cnt: code=%0d cnt=%0d want code=%0d cnt=%0d",
                     o_err_code, o_byte_cnt, e.code, e.cnt); else n_pass++;
        frame_q = '{8'h01, 8'h03, 8'h00};
        sb_q.push_back(mk_err(3'd1));
        send_frame();
        wait_pulse(v, er);
        e = sb_q.pop_front();
        n_chk++; if (v !== e.v || er !== e.er)
            $display("FAIL short_pulse: valid=%b err=%b want valid=%b err=%b", v, er, e.v, e.er); else n_pass++;
        n_chk++; if (o_err_code !== e.code)
            $display("FAIL short_code: got %0d want %0d", o_err_code, e.code); else n_pass++;
    endtask

    task automatic test_max_len();
        frame_q = '{8'h01, 8'h10, 8'h00, 8'h20, 8'h00, 8'h1B};
        for (int k = 6; k < 62; k++) frame_q.push_back(8'(k * 3));
        append_crc();
        sb_q.push_back(mk_ok(8'h10, 16'h0020, 16'h001B, 7'd64, 1'b0));
        test_good_frame("max_len");
    endtask

    task automatic test_reset_midframe();
        int n;
        frame_q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
        append_crc();
        for (int k = 0; k < 4; k++) begin
            strobe(frame_q[k]);
            repeat (SPACING - 1) @(negedge i_clk);
        end
        rst_n = 1'b0;
        repeat (5) @(negedge i_clk);
        rst_n = 1'b1;
        count_pulses(n);
        n_chk++; if (n !== 0) $display("FAIL rstmid_pulses: got %0d want 0", n); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", o_busy); else n_pass++;
        sb_q.push_back(mk_ok(8'h06, 16'h0001, 16'h0003, 7'd8, 1'b0));
        test_good_frame("after_reset");
    endtask

    task automatic test_broadcast();
        frame_q = '{8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h02, 8'h04, 8'h00, 8'h0A, 8'h01, 8'h02};
        append_crc();
        sb_q.push_back(mk_ok(8'h10, 16'h0001, 16'h0002, 7'd13, 1'b1));
        test_good_frame("bcast");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc_err();
        test_addr_filter();
        test_gap();
        test_overflow_short();
        test_max_len();
        test_reset_midframe();
        test_broadcast();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/modbus_rtu_rx_framer.md
Name: modbus_rtu_rx_framer

Overview:
- Sits between the RS485 UART receiver and the screen protocol handler. Consumes received bytes in the 29.4912 MHz clock domain.
- Delimits Modbus-RTU frames by t1.5/t3.5 line silence and checks CRC-16 (poly 0xA001, init 0xFFFF). Filters frames on slave address.
- Presents decoded header fields plus a byte-buffer read port to the command decoder (function 03/06/10 handling).

Parameters:
- CLK_HZ, 29491200, i_clk frequency.
- BAUD, 9600, line rate. Derived: BIT_CYC=CLK_HZ/BAUD; T15_CYC=BIT_CYC*33/2; T35_CYC=BIT_CYC*77/2.
- SLAVE_ADDR, 8'h01, own station address; 8'h00 = broadcast, also accepted.
- MAX_LEN, 64, buffer depth in bytes, including the 2 CRC bytes.

Ports:
- i_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_rx_data  in  8  byte from UART receiver
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in the same cycle
- i_rd_addr  in  6  buffer read address (byte index, 0 = address byte)
- o_rd_data  out  8  buffer byte, 1-cycle registered latency
- o_frame_valid  out  1  one-cycle pulse: good frame for this station
- o_frame_err  out  1  one-cycle pulse: frame rejected
- o_err_code  out  3  1 short, 2 crc, 3 overflow, 4 gap violation; held until next pulse
- o_broadcast  out  1  latched frame address was 00
- o_func  out  8  byte 1
- o_reg_addr  out  16  bytes 2..3, big-endian
- o_reg_val  out  16  bytes 4..5, big-endian (quantity for 03/10, value for 06)
- o_byte_cnt  out  7  total stored bytes, including CRC
- o_busy  out  1  high from the first byte until the result pulse

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register 16'hFFFF, idle counter 0.
- Idle counter: cleared on every i_rx_valid; otherwise increments, saturating at T35_CYC.
- IDLE: on i_rx_valid, store byte at index 0, start CRC update, cnt=1 -> RECV.
- RECV: on i_rx_valid, store the byte if cnt<MAX_LEN, else set the overflow flag and drop it; cnt saturates at MAX_LEN. When counter==T15_CYC -> GAP.
- GAP: on i_rx_valid -> DISCARD with err=4. When counter==T35_CYC -> CHECK. If both happen in the same cycle, the byte wins (DISCARD).
- DISCARD: ignore bytes; each byte restarts the counter. When counter==T35_CYC -> emit o_frame_err with the latched code -> IDLE.
- CHECK: wait until the CRC engine is not busy (≤8 cycles), then evaluate in priority order:
  - overflow -> err 3
  - cnt<4 -> err 1
  - CRC residue != 0 -> err 2
  - address not SLAVE_ADDR and not 00 -> silent drop; no pulse, fields unchanged
  - otherwise -> latch o_func/o_reg_addr/o_reg_val/o_byte_cnt/o_broadcast and pulse o_frame_valid
- After CHECK: -> IDLE; o_busy falls in the same cycle as the pulse.
- CRC: running CRC over every stored byte, including the received CRC bytes. A residue of 16'h0000 means pass. CRC is reinitialised to FFFF on entry to IDLE.
- CRC processing: serial, 1 bit per cycle, 8 cycles per byte. Spacing between i_rx_valid strobes is guaranteed ≥11*BIT_CYC. A strobe while the CRC engine is busy is a protocol violation; the bench asserts on it.
- Field outputs: o_reg_addr/o_reg_val are taken from buffer bytes 2..5. For cnt<8 they are still latched, but their content is don't-care.
- Read port: usable at any time. While a new frame is arriving, the buffer is being overwritten, and the reader must sample before the next frame start.
- Reset mid-frame: buffer content is lost, no pulse is emitted, state returns to IDLE.

Decomposition:
- Package modbus_rtu_pkg holds:
  - err code constants ERR_NONE/SHORT/CRC/OVF/GAP
  - state enum
  - CRC poly 16'hA001 and init 16'hFFFF
  - function codes 03/06/10
- One sub-module, crc16_modbus_serial: byte in, start strobe, busy, 16-bit crc register, clear input.
- Buffer: MAX_LEN x 8 register array with a registered read.

Test Plan:
- Bytes 01 03 00 00 00 0A C5 CD at 33792-cycle spacing, then silence -> about T35_CYC+8 cycles after the last byte: o_frame_valid=1, o_func=03, o_reg_addr=0000, o_reg_val=000A, o_byte_cnt=8, o_broadcast=0.
- Same frame with the last byte CC -> o_frame_err=1, o_err_code=2, no o_frame_valid.
- Same frame with address 05 and a recomputed correct CRC -> no pulse at all, o_busy returns to 0, fields keep their previous values.
- Gap violation: 01 03 00, then 60000 idle cycles, then 00 -> after T35 silence: o_frame_err, code 4. Then the good frame -> o_frame_valid.
- 70 bytes at normal spacing -> o_err_code=3, o_byte_cnt unchanged. 3 bytes 01 03 00 -> code 1.
- rst_n low for 5 cycles after byte 4 of a good frame -> no pulse. The following full frame decodes correctly. Broadcast frame addressed 00 -> o_frame_valid with o_broadcast=1.
